// File: rtl/fetch_pkg.sv
// cpu_types: shared fetch-stage types and constants
package cpu_types;
   typedef enum logic {S_REQ, S_WAIT} fetch_state_t;
   localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response and decode-side buffer signals
interface fetch_if #(parameter int WIDTH = 32);
   logic mem_req, mem_ready, mem_rvalid, out_valid, out_ready;
   logic [WIDTH-1:0] mem_addr, mem_rdata, out_pc, out_instruction;
   modport master(
      output mem_req, mem_addr, out_valid, out_pc, out_instruction,
      input mem_ready, mem_rvalid, mem_rdata, out_ready
   );
   modport slave(
      input mem_req, mem_addr, out_valid, out_pc, out_instruction,
      output mem_ready, mem_rvalid, mem_rdata, out_ready
   );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry instruction holding register toward decode
module fetch_buffer #(parameter int WIDTH = 32) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic load,
   input  logic consume,
   input  logic [WIDTH-1:0] load_pc,
   input  logic [WIDTH-1:0] load_instruction,
   output logic valid,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] instruction
);
   always_ff @(posedge clk)
      if (rst) begin
         valid <= 1'b0;
         pc <= '0;
         instruction <= '0;
      end else if (flush) valid <= 1'b0;
      else if (load) begin
         valid <= 1'b1;
         pc <= load_pc;
         instruction <= load_instruction;
      end else if (consume) valid <= 1'b0;
endmodule

// File: rtl/fetch.sv
// fetch: owns the fetch PC, issues single-outstanding memory requests and
// discards wrong-path work on redirect
module fetch import cpu_types::*; #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input logic clk,
   input logic rst,
   input logic jump,
   input logic [WIDTH-1:0] jump_pc,
   fetch_if.master bus
);
   fetch_state_t state, state_n;
   logic [WIDTH-1:0] pc, pc_n, req_pc;
   logic drop, drop_n, handshake, load;
   // a request only goes out when the buffer is guaranteed free next cycle
   assign bus.mem_req = !rst && state == S_REQ && (!bus.out_valid || bus.out_ready);
   assign bus.mem_addr = pc;
   assign handshake = bus.mem_req && bus.mem_ready;
   always_comb begin
      load = state == S_WAIT && bus.mem_rvalid && !drop && !jump;
      state_n = state == S_REQ ? (handshake ? S_WAIT : S_REQ) : (bus.mem_rvalid ? S_REQ : S_WAIT);
      drop_n = state == S_REQ ? handshake && jump : !bus.mem_rvalid && (drop || jump);
      pc_n = jump ? jump_pc & ~WIDTH'(~INSTR_ALIGN_MASK) : handshake ? pc + WIDTH'(4) : pc;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= S_REQ;
         pc <= RESET_PC;
         drop <= 1'b0;
         req_pc <= '0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         drop <= drop_n;
         if (handshake) req_pc <= pc;
      end
   fetch_buffer #(.WIDTH(WIDTH)) u_buf (
      .clk(clk),
      .rst(rst),
      .flush(jump),
      .load(load),
      .consume(bus.out_valid && bus.out_ready),
      .load_pc(req_pc),
      .load_instruction(bus.mem_rdata),
      .valid(bus.out_valid),
      .pc(bus.out_pc),
      .instruction(bus.out_instruction)
   );
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: vector table plus directed sequences; a scoreboard queue holds
// the PCs expected to reach decode, in order
module tb_fetch;
   localparam logic [31:0] MAGIC = 32'hA5A5_0000;
   typedef struct {
      logic o, m, j;
      logic [31:0] jp;
      logic req;
      logic [31:0] addr;
      logic ov;
      logic [31:0] opc;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, jump = 1'b0;
   logic [31:0] jump_pc = '0, raddr = '0;
   int lat = 1, cnt = 0, checks = 0, passed = 0;
   bit busy = 1'b0;
   logic [31:0] sb[$];
   vec_t tbl[9];
   fetch_if #(.WIDTH(32)) bus();
   fetch #(.WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .jump(jump), .jump_pc(jump_pc), .bus(bus)
   );
   always #5 clk = ~clk;
   // instruction memory: one response per accepted request after lat cycles
   always @(posedge clk) begin
      bus.mem_rvalid <= 1'b0;
      if (rst) busy <= 1'b0;
      else begin
         if (busy) begin
            if (cnt == 1) begin
               bus.mem_rvalid <= 1'b1;
               bus.mem_rdata <= raddr ^ MAGIC;
               busy <= 1'b0;
            end else cnt <= cnt - 1;
         end
         if (bus.mem_req && bus.mem_ready) begin
            if (lat == 1) begin
               bus.mem_rvalid <= 1'b1;
               bus.mem_rdata <= bus.mem_addr ^ MAGIC;
            end else begin
               busy <= 1'b1;
               raddr <= bus.mem_addr;
               cnt <= lat - 1;
            end
         end
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic tick(input logic o, input logic m, input logic j, input logic [31:0] jp);
      logic [31:0] e;
      @(negedge clk);
      bus.out_ready = o;
      bus.mem_ready = m;
      jump = j;
      jump_pc = jp;
      #1;
      if (bus.out_valid && o && !j) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected transfer: got pc %h expected none", bus.out_pc);
         end else begin
            e = sb.pop_front();
            chk("xfer pc", bus.out_pc, e);
            chk("xfer instr", bus.out_instruction, e ^ MAGIC);
         end
      end
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      jump = 1'b0;
      bus.out_ready = 1'b1;
      bus.mem_ready = 1'b1;
      lat = 1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", 32'(bus.out_valid), 0);
      chk("rst out_pc", bus.out_pc, 0);
      chk("rst out_instr", bus.out_instruction, 0);
      chk("rst mem_req", 32'(bus.mem_req), 0);
      rst = 1'b0;
   endtask
   task automatic drained();
      chk("sb drained", 32'(sb.size()), 0);
   endtask
   initial begin
      bus.out_ready = 1'b1;
      bus.mem_ready = 1'b1;
      // streaming: one instruction every two cycles
      tbl[0] = '{1, 1, 0, 0, 1, 32'h0, 0, 0};
      tbl[1] = '{1, 1, 0, 0, 0, 32'h0, 0, 0};
      tbl[2] = '{1, 1, 0, 0, 1, 32'h4, 1, 32'h0};
      tbl[3] = '{1, 1, 0, 0, 0, 32'h0, 0, 0};
      tbl[4] = '{1, 1, 0, 0, 1, 32'h8, 1, 32'h4};
      tbl[5] = '{1, 1, 0, 0, 0, 32'h0, 0, 0};
      tbl[6] = '{1, 1, 0, 0, 1, 32'hC, 1, 32'h8};
      tbl[7] = '{1, 1, 0, 0, 0, 32'h0, 0, 0};
      tbl[8] = '{1, 1, 0, 0, 1, 32'h10, 1, 32'hC};
      do_reset();
      sb = {32'h0, 32'h4, 32'h8, 32'hC};
      foreach (tbl[i]) begin
         tick(tbl[i].o, tbl[i].m, tbl[i].j, tbl[i].jp);
         chk("tbl mem_req", 32'(bus.mem_req), 32'(tbl[i].req));
         if (tbl[i].req) chk("tbl mem_addr", bus.mem_addr, tbl[i].addr);
         chk("tbl out_valid", 32'(bus.out_valid), 32'(tbl[i].ov));
         if (tbl[i].ov) chk("tbl out_pc", bus.out_pc, tbl[i].opc);
      end
      drained();
      // memory stall at address 8
      do_reset();
      sb = {32'h0, 32'h4, 32'h8};
      run(4);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 1'b0, 32'h0);
         chk("stall req", 32'(bus.mem_req), 1);
         chk("stall addr", bus.mem_addr, 32'h8);
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("accept addr", bus.mem_addr, 32'h8);
      run(2);
      drained();
      // decode backpressure with pc 4 buffered
      do_reset();
      sb = {32'h0, 32'h4, 32'h8};
      run(4);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b0, 32'h0);
         chk("bp req", 32'(bus.mem_req), 0);
         chk("bp out_valid", 32'(bus.out_valid), 1);
         chk("bp out_pc", bus.out_pc, 32'h4);
         chk("bp out_instr", bus.out_instruction, 32'h4 ^ MAGIC);
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("bp release req", 32'(bus.mem_req), 1);
      chk("bp release addr", bus.mem_addr, 32'h8);
      run(2);
      drained();
      // redirect while waiting for address C, slow response dropped
      do_reset();
      sb = {32'h0, 32'h4, 32'h8, 32'h100};
      run(6);
      lat = 3;
      run(1);
      tick(1'b1, 1'b1, 1'b1, 32'h103);
      chk("j4 c7 req", 32'(bus.mem_req), 0);
      run(1);
      chk("j4 c8 out_valid", 32'(bus.out_valid), 0);
      run(1);
      chk("j4 c9 out_valid", 32'(bus.out_valid), 0);
      chk("j4 c9 req", 32'(bus.mem_req), 0);
      lat = 1;
      run(1);
      chk("j4 c10 out_valid", 32'(bus.out_valid), 0);
      chk("j4 c10 req", 32'(bus.mem_req), 1);
      chk("j4 c10 addr", bus.mem_addr, 32'h100);
      run(2);
      drained();
      // redirect coinciding with a response
      do_reset();
      sb = {32'h200};
      run(1);
      tick(1'b1, 1'b1, 1'b1, 32'h200);
      chk("j5a out_valid", 32'(bus.out_valid), 0);
      run(1);
      chk("j5a next out_valid", 32'(bus.out_valid), 0);
      chk("j5a addr", bus.mem_addr, 32'h200);
      run(2);
      drained();
      // redirect coinciding with a request handshake
      do_reset();
      sb = {32'h200};
      tick(1'b1, 1'b1, 1'b1, 32'h200);
      chk("j5b old req", 32'(bus.mem_req), 1);
      chk("j5b old addr", bus.mem_addr, 32'h0);
      run(1);
      chk("j5b out_valid", 32'(bus.out_valid), 0);
      run(1);
      chk("j5b out_valid2", 32'(bus.out_valid), 0);
      chk("j5b req", 32'(bus.mem_req), 1);
      chk("j5b addr", bus.mem_addr, 32'h200);
      run(2);
      drained();
      // second redirect while the in-flight response is already marked dropped
      do_reset();
      sb = {32'h300};
      lat = 3;
      tick(1'b1, 1'b1, 1'b1, 32'h200);
      tick(1'b1, 1'b1, 1'b1, 32'h300);
      run(2);
      chk("j2 out_valid", 32'(bus.out_valid), 0);
      lat = 1;
      run(1);
      chk("j2 req", 32'(bus.mem_req), 1);
      chk("j2 addr", bus.mem_addr, 32'h300);
      run(2);
      drained();
      // reset while a response is arriving in S_WAIT
      do_reset();
      sb = {32'h0};
      run(3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("mid rst out_valid", 32'(bus.out_valid), 0);
      chk("mid rst req", 32'(bus.mem_req), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run(1);
      chk("post rst req", 32'(bus.mem_req), 1);
      chk("post rst addr", bus.mem_addr, 32'h0);
      // reset while the buffer holds an instruction
      run(1);
      tick(1'b0, 1'b1, 1'b0, 32'h0);
      chk("held out_valid", 32'(bus.out_valid), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst2 out_valid", 32'(bus.out_valid), 0);
      chk("rst2 out_pc", bus.out_pc, 0);
      chk("rst2 req", 32'(bus.mem_req), 0);
      drained();
      // PC wraps past the top of the address space
      do_reset();
      sb = {32'hFFFF_FFFC};
      tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
      run(1);
      chk("wrap req", 32'(bus.mem_req), 1);
      chk("wrap addr", bus.mem_addr, 32'hFFFF_FFFC);
      run(2);
      chk("wrap next addr", bus.mem_addr, 32'h0);
      drained();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
